// File: rtl/transposer_pingpong_if.sv
// rtl/transposer_pingpong_if.sv - row-in / column-out handshake bundle; stats ports under TRANSPOSER_STATS_EN
interface transposer_pingpong_if #(
  parameter int DIM = 16,
  parameter int W   = 8
);
  logic               io_inRow_valid;
  logic [DIM*W-1:0]   io_inRow_bits;
  logic               io_inRow_ready;
  logic               io_outCol_valid;
  logic [DIM*W-1:0]   io_outCol_bits;
  logic               io_outCol_ready;
`ifdef TRANSPOSER_STATS_EN
  logic [31:0]        io_stat_mats;
  logic [31:0]        io_stat_stalls;
`endif

  modport master (
    output io_inRow_valid,
    output io_inRow_bits,
    input  io_inRow_ready,
    input  io_outCol_valid,
    input  io_outCol_bits,
    output io_outCol_ready
`ifdef TRANSPOSER_STATS_EN
    , input io_stat_mats
    , input io_stat_stalls
`endif
  );

  modport slave (
    input  io_inRow_valid,
    input  io_inRow_bits,
    output io_inRow_ready,
    output io_outCol_valid,
    output io_outCol_bits,
    input  io_outCol_ready
`ifdef TRANSPOSER_STATS_EN
    , output io_stat_mats
    , output io_stat_stalls
`endif
  );
endinterface

// File: rtl/transposer_pingpong.sv
// rtl/transposer_pingpong.sv - ping-pong DIM x DIM matrix transposer; optional counters under TRANSPOSER_STATS_EN
module transposer_pingpong #(
  parameter int DIM = 16,
  parameter int W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  transposer_pingpong_if.slave  io
);
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [AW-1:0] LAST = AW'(DIM - 1);

  // Two banks of DIM rows; contents are never reset, only the full flags are.
  logic [W-1:0]  mem [2][DIM][DIM];
  logic [1:0]    full;
  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_row;
  logic [AW-1:0] rd_col;

  logic          in_fire;
  logic          out_fire;
  logic          wr_last;
  logic          rd_last;
  logic [1:0]    set_full;
  logic [1:0]    clr_full;

  // Ready and valid come from registered flags only, so neither side sees a combinational path from the other.
  assign io.io_inRow_ready  = !full[wr_bank];
  assign io.io_outCol_valid = full[rd_bank];

  assign in_fire  = io.io_inRow_valid && !full[wr_bank];
  assign out_fire = full[rd_bank] && io.io_outCol_ready;
  assign wr_last  = in_fire && (wr_row == LAST);
  assign rd_last  = out_fire && (rd_col == LAST);

  // Per-bank set/clear requests for the full flags.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (wr_last) set_full[wr_bank] = 1'b1;
    if (rd_last) clr_full[rd_bank] = 1'b1;
  end

  // Row storage: an accepted row lands in the current write bank at wr_row.
  always_ff @(posedge clock) begin
    if (in_fire) begin
      for (int i = 0; i < DIM; i++) begin
        mem[wr_bank][wr_row][i] <= io.io_inRow_bits[i*W +: W];
      end
    end
  end

  // Write/read pointers and bank full flags; a clear beats a set on the same bank.
  always_ff @(posedge clock) begin
    if (reset) begin
      full    <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_row  <= '0;
      rd_col  <= '0;
    end else begin
      if (in_fire) begin
        if (wr_row == LAST) begin
          wr_row  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_row <= wr_row + AW'(1);
        end
      end
      if (out_fire) begin
        if (rd_col == LAST) begin
          rd_col  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_col <= rd_col + AW'(1);
        end
      end
      full <= (full | set_full) & ~clr_full;
    end
  end

  // Writer only fills a non-full bank and reader only drains a full one, so set and clear never collide.
  a_no_set_clr_same_bank: assert property (@(posedge clock) disable iff (reset) (set_full & clr_full) == 2'b00);

  // Column mux: element j of the output is row j, column rd_col of the read bank.
  always_comb begin
    io.io_outCol_bits = '0;
    for (int j = 0; j < DIM; j++) begin
      io.io_outCol_bits[j*W +: W] = mem[rd_bank][j][rd_col];
    end
  end

`ifdef TRANSPOSER_STATS_EN
  logic [31:0] stat_mats;
  logic [31:0] stat_stalls;

  assign io.io_stat_mats   = stat_mats;
  assign io.io_stat_stalls = stat_stalls;

  // Completed-matrix and upstream-stall counters, both free-running with wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_mats   <= '0;
      stat_stalls <= '0;
    end else begin
      if (rd_last) stat_mats <= stat_mats + 32'd1;
      if (io.io_inRow_valid && full[wr_bank]) stat_stalls <= stat_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_transposer_pingpong.sv
// tb/tb_transposer_pingpong.sv - directed and table-driven bench for transposer_pingpong (DIM=4, W=8)
module tb_transposer_pingpong;
  localparam int DIM = 4;
  localparam int W   = 8;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  transposer_pingpong_if #(.DIM(DIM), .W(W)) tif ();

  transposer_pingpong #(.DIM(DIM), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .io    (tif)
  );

  typedef struct packed {
    logic [3:0][31:0] rows;
    logic [3:0][31:0] cols;
  } vec_t;

  vec_t        tbl [4];
  logic [31:0] row_q [$];
  logic [31:0] exp_q [$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          stall_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offers queued rows; pv is the percent chance of asserting valid in a cycle.
  task automatic driver(input int pv, input int budget);
    int cyc = 0;
    while (row_q.size() > 0 && cyc < budget) begin
      @(negedge clock);
      cyc++;
      tif.io_inRow_valid = ($urandom_range(99) < pv);
      tif.io_inRow_bits  = tif.io_inRow_valid ? row_q[0] : $urandom;
      #1;
      if (tif.io_inRow_valid && tif.io_inRow_ready) void'(row_q.pop_front());
      else if (tif.io_inRow_valid) stall_cnt++;
    end
    @(negedge clock);
    tif.io_inRow_valid = 1'b0;
    check("driver_done", row_q.size(), 0);
  endtask

  // Consumes ncols columns against exp_q; pr is the percent chance of ready.
  task automatic monitor(input int pr, input int ncols, input int budget);
    int cyc = 0;
    int got = 0;
    logic [31:0] held = '0;
    logic hold_v = 1'b0;
    while (got < ncols && cyc < budget) begin
      @(negedge clock);
      cyc++;
      tif.io_outCol_ready = ($urandom_range(99) < pr);
      #1;
      if (hold_v && tif.io_outCol_valid) check("stable_bits", tif.io_outCol_bits, held);
      hold_v = 1'b0;
      if (tif.io_outCol_valid && tif.io_outCol_ready) begin
        check("col", tif.io_outCol_bits, exp_q.pop_front());
        got++;
      end else if (tif.io_outCol_valid) begin
        hold_v = 1'b1;
        held   = tif.io_outCol_bits;
      end
    end
    @(negedge clock);
    tif.io_outCol_ready = 1'b0;
    check("monitor_done", got, ncols);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0][31:0] rr;
    logic [31:0]      cc;
    logic [31:0]      all_rows [12];
    int               idx;

    tbl[0].rows = {32'h33323130, 32'h23222120, 32'h13121110, 32'h03020100};
    tbl[0].cols = {32'h33231303, 32'h32221202, 32'h31211101, 32'h30201000};
    tbl[1].rows = {32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF};
    tbl[1].cols = {32'hFF000000, 32'h00FF0000, 32'h0000FF00, 32'h000000FF};
    tbl[2].rows = {32'h04040404, 32'h03030303, 32'h02020202, 32'h01010101};
    tbl[2].cols = {32'h04030201, 32'h04030201, 32'h04030201, 32'h04030201};
    tbl[3].rows = {32'hAFAEADAC, 32'hABAAA9A8, 32'hA7A6A5A4, 32'hA3A2A1A0};
    tbl[3].cols = {32'hAFABA7A3, 32'hAEAAA6A2, 32'hADA9A5A1, 32'hACA8A4A0};

    tif.io_inRow_valid  = 1'b0;
    tif.io_inRow_bits   = '0;
    tif.io_outCol_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_in_ready", 32'(tif.io_inRow_ready), 32'd1);
    check("rst_out_valid", 32'(tif.io_outCol_valid), 32'd0);
`ifdef TRANSPOSER_STATS_EN
    check("rst_stat_mats", tif.io_stat_mats, 32'd0);
    check("rst_stat_stalls", tif.io_stat_stalls, 32'd0);
`endif

    // Scenario 1: single matrix, first column the cycle after the last row
    for (int r = 0; r < DIM; r++) begin
      @(negedge clock);
      tif.io_inRow_valid = 1'b1;
      tif.io_inRow_bits  = tbl[0].rows[r];
      #1;
      check("t1_in_ready", 32'(tif.io_inRow_ready), 32'd1);
      check("t1_no_valid_yet", 32'(tif.io_outCol_valid), 32'd0);
    end
    for (int c = 0; c < DIM; c++) begin
      @(negedge clock);
      tif.io_inRow_valid  = 1'b0;
      tif.io_outCol_ready = 1'b1;
      #1;
      check("t1_valid", 32'(tif.io_outCol_valid), 32'd1);
      check("t1_col", tif.io_outCol_bits, tbl[0].cols[c]);
    end
    @(negedge clock);
    tif.io_outCol_ready = 1'b0;
    #1;
    check("t1_drained", 32'(tif.io_outCol_valid), 32'd0);

    // Scenario 2: table vectors 1..3 back to back at full rate
    stall_cnt = 0;
    for (int v = 1; v < 4; v++) begin
      for (int r = 0; r < DIM; r++) row_q.push_back(tbl[v].rows[r]);
      for (int c = 0; c < DIM; c++) exp_q.push_back(tbl[v].cols[c]);
    end
    fork
      driver(100, 100);
      monitor(100, 12, 100);
    join
    check("t2_no_stall", stall_cnt, 0);

    // Scenario 3: output stalled while three matrices are offered
    for (int v = 0; v < 3; v++)
      for (int r = 0; r < DIM; r++) all_rows[v*DIM + r] = tbl[v].rows[r];
    idx = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      @(negedge clock);
      tif.io_inRow_valid = 1'b1;
      tif.io_inRow_bits  = all_rows[idx];
      #1;
      if (tif.io_inRow_ready) idx++;
    end
    check("t3_accepted", idx, 8);
    check("t3_in_blocked", 32'(tif.io_inRow_ready), 32'd0);
    for (int c = 0; c < DIM; c++) begin
      @(negedge clock);
      tif.io_inRow_valid  = 1'b0;
      tif.io_outCol_ready = 1'b1;
      #1;
      check("t3_valid", 32'(tif.io_outCol_valid), 32'd1);
      check("t3_m0_col", tif.io_outCol_bits, tbl[0].cols[c]);
      check("t3_still_blocked", 32'(tif.io_inRow_ready), 32'd0);
    end
    @(negedge clock);
    tif.io_outCol_ready = 1'b0;
    #1;
    check("t3_ready_back", 32'(tif.io_inRow_ready), 32'd1);
    check("t3_m1_waiting", 32'(tif.io_outCol_valid), 32'd1);
`ifdef TRANSPOSER_STATS_EN
    check("t6_stat_mats", tif.io_stat_mats, 32'd5);
    check("t6_stat_stalls", tif.io_stat_stalls, 32'd4);
`endif
    for (int r = 0; r < DIM; r++) row_q.push_back(tbl[2].rows[r]);
    for (int c = 0; c < DIM; c++) exp_q.push_back(tbl[1].cols[c]);
    for (int c = 0; c < DIM; c++) exp_q.push_back(tbl[2].cols[c]);
    fork
      driver(100, 100);
      monitor(100, 8, 100);
    join

    // Scenario 4: random valid/ready, golden transpose of random matrices
    for (int m = 0; m < 20; m++) begin
      for (int r = 0; r < DIM; r++) begin
        rr[r] = $urandom;
        row_q.push_back(rr[r]);
      end
      for (int c = 0; c < DIM; c++) begin
        for (int j = 0; j < DIM; j++) cc[j*W +: W] = rr[j][c*W +: W];
        exp_q.push_back(cc);
      end
    end
    fork
      driver(60, 2000);
      monitor(50, 20*DIM, 3000);
    join

    // Scenario 5: reset with one matrix full and two rows of the next taken
    for (int r = 0; r < DIM; r++) row_q.push_back(tbl[0].rows[r]);
    row_q.push_back(tbl[1].rows[0]);
    row_q.push_back(tbl[1].rows[1]);
    driver(100, 50);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("t5_valid_low", 32'(tif.io_outCol_valid), 32'd0);
    check("t5_ready_high", 32'(tif.io_inRow_ready), 32'd1);
`ifdef TRANSPOSER_STATS_EN
    check("t5_stat_mats", tif.io_stat_mats, 32'd0);
`endif
    for (int r = 0; r < DIM; r++) row_q.push_back(tbl[3].rows[r]);
    for (int c = 0; c < DIM; c++) exp_q.push_back(tbl[3].cols[c]);
    fork
      driver(100, 100);
      monitor(100, 4, 100);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
